ahb_sram_master: RTL and testbench

- AHB-Lite initiator that drives the SRAM controller's slave port. The SRAM controller's hready_resp, hresp and hrdata feed this block's hready, hresp and hrdata.
- Converts a simple command/data handshake into pipelined AHB address and data phases: SINGLE, INCR4/8/16, and optional WRAP bursts.
- Used by the testbench traffic generator and by on-chip DMA/boot loaders that fill SRAM.

---
 rtl/ahb_pkg.sv | 49 ++++
 rtl/ahb_sram_master_if.sv | 31 +++
 rtl/ahb_addr_gen.sv | 32 +++
 rtl/ahb_sram_master.sv | 212 +++++++++++++++++++++
 tb/tb_ahb_sram_master.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the SRAM initiator.
// Contents: htrans/hburst/hresp/hsize encodings, the initiator FSM state type and
// small helpers that decode hburst into a beat count and a wrap flag.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_LAST = 2'd2;
    localparam state_t ST_ERR  = 2'd3;

    // log2 of the beat count; SINGLE and undefined-length INCR both give one beat.
    function automatic logic [2:0] burst_len_log2(input logic [2:0] burst);
        logic [2:0] len;
        unique case (burst[2:1])
            2'b00:   len = 3'd0;
            2'b01:   len = 3'd2;
            2'b10:   len = 3'd3;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

    function automatic logic burst_is_wrap(input logic [2:0] burst);
        return (burst[2:1] != 2'b00) && !burst[0];
    endfunction

endpackage

// File: rtl/ahb_sram_master_if.sv
// AHB-Lite bus bundle between the SRAM initiator and the SRAM controller slave port.
// master modport: drives hsel/haddr/htrans/hwrite/hsize/hburst/hwdata,
//                 receives hready/hresp/hrdata.
// slave modport:  the reverse direction.
interface ahb_sram_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
        output hready, hresp, hrdata
    );

endinterface

// File: rtl/ahb_addr_gen.sv
// Combinational next-beat address for AHB bursts.
// Ports: addr (current beat address), size (hsize, 0..2), next_addr (following beat).
// With AHB_SRAM_MST_WRAP_EN defined, extra inputs wrap/len_log2 select wrapping within
// a (beats x bytes) aligned window; otherwise only linear increment is built.
module ahb_addr_gen #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
`ifdef AHB_SRAM_MST_WRAP_EN
    input  logic              wrap,
    input  logic [2:0]        len_log2,
`endif
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] incr_addr;

    // Natural modulo-2^ADDR_W rollover.
    assign incr_addr = addr + (ADDR_W'(1) << size);

`ifdef AHB_SRAM_MST_WRAP_EN
    logic [ADDR_W-1:0] wrap_mask;

    // Low log2(beats*bytes) bits wrap, upper bits stay put.
    assign wrap_mask = (ADDR_W'(1) << ({1'b0, len_log2} + {1'b0, size})) - ADDR_W'(1);
    assign next_addr = wrap ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
`else
    assign next_addr = incr_addr;
`endif

endmodule

// File: rtl/ahb_sram_master.sv
// AHB-Lite initiator for the SRAM controller slave port.
// Turns a command/data handshake into pipelined AHB address and data phases
// (SINGLE, INCR4/8/16; WRAP4/8/16 when AHB_SRAM_MST_WRAP_EN is defined, otherwise
// wrap codes are issued as INCR of the same length).
// Ports:
//   hclk, hreset        clock and synchronous active-high reset
//   cmd_*               command request; accepted on cmd_valid & cmd_ready
//   wr_ready/wr_data    write data pulled one beat at a time
//   rd_valid/rd_data    registered read beats
//   done/err            end-of-command pulse and error flag
//   bus                 AHB-Lite master modport
module ahb_sram_master
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [2:0]        cmd_burst,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    ahb_sram_master_if.master bus
);

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [4:0]        beats_q, beats_d;     // address phases still to complete
    logic              dphase_q, dphase_d;   // a data phase is in flight this cycle
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [2:0]        size_clip;
    logic [2:0]        burst_map;
    logic [ADDR_W-1:0] next_addr;
    logic              data_err;

    assign size_clip = (cmd_size > HSIZE_WORD) ? HSIZE_WORD : cmd_size;
    assign data_err  = dphase_q && (bus.hresp == HRESP_ERROR);

    always_comb begin
        if (cmd_burst[2:1] == 2'b00) begin
            burst_map = HBURST_SINGLE;
        end else begin
`ifdef AHB_SRAM_MST_WRAP_EN
            burst_map = cmd_burst;
`else
            burst_map = {cmd_burst[2:1], 1'b1};
`endif
        end
    end

    ahb_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .addr      (haddr_q),
        .size      (hsize_q),
`ifdef AHB_SRAM_MST_WRAP_EN
        .wrap      (burst_is_wrap(hburst_q)),
        .len_log2  (burst_len_log2(hburst_q)),
`endif
        .next_addr (next_addr)
    );

    always_comb begin
        state_d    = state_q;
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hburst_d   = hburst_q;
        hwdata_d   = hwdata_q;
        beats_d    = beats_q;
        dphase_d   = dphase_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_ready   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    hwrite_d = cmd_write;
                    hsize_d  = size_clip;
                    hburst_d = burst_map;
                    haddr_d  = cmd_addr;
                    beats_d  = 5'd1 << burst_len_log2(cmd_burst);
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR, ST_LAST: begin
                // A data-phase error beats any address completing in the same cycle.
                if (data_err && !bus.hready) begin
                    htrans_d = HTRANS_IDLE;
                    beats_d  = '0;
                    state_d  = ST_ERR;
                end else if (data_err) begin
                    htrans_d = HTRANS_IDLE;
                    beats_d  = '0;
                    dphase_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else if (bus.hready) begin
                    if (dphase_q && !hwrite_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bus.hrdata;
                    end
                    if (state_q == ST_LAST) begin
                        dphase_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        dphase_d = 1'b1;
                        beats_d  = beats_q - 5'd1;
                        haddr_d  = next_addr;
                        if (hwrite_q) begin
                            wr_ready = 1'b1;
                            hwdata_d = wr_data;
                        end
                        if (beats_q == 5'd1) begin
                            htrans_d = HTRANS_IDLE;
                            state_d  = ST_LAST;
                        end else begin
                            htrans_d = HTRANS_SEQ;
                        end
                    end
                end
            end
            ST_ERR: begin
                // Second cycle of the two-cycle ERROR response.
                if (bus.hready) begin
                    dphase_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hburst_q    <= '0;
            hwdata_q    <= '0;
            beats_q     <= '0;
            dphase_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hwdata_q    <= hwdata_d;
            beats_q     <= beats_d;
            dphase_q    <= dphase_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign done        = done_q;
    assign err         = err_q;

    assign bus.hsel   = (htrans_q != HTRANS_IDLE);
    assign bus.haddr  = haddr_q;
    assign bus.htrans = htrans_q;
    assign bus.hwrite = hwrite_q;
    assign bus.hsize  = hsize_q;
    assign bus.hburst = hburst_q;
    assign bus.hwdata = hwdata_q;

endmodule

// File: tb/tb_ahb_sram_master.sv
// Self-checking bench for ahb_sram_master with a small AHB SRAM slave model that can
// insert wait states and two-cycle ERROR responses on a chosen beat.
module tb_ahb_sram_master;
    import ahb_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [2:0]  size;
    } addr_exp_t;

    logic        hclk;
    logic        hreset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [2:0]  cmd_burst;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        err;

    ahb_sram_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_sram_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_burst (cmd_burst),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_fail   = 0;

    addr_exp_t   exp_addr_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wdata_q[$];
    logic [31:0] wr_src_q[$];

    // ---------------- slave model ----------------
    logic [31:0] mem [0:1023];
    logic        dp_valid;
    logic        dp_write;
    logic [31:0] dp_addr;
    int          dp_idx;
    int          beat_next;
    int          wait_cnt;
    logic        err_phase;
    int          stall_beat;
    int          stall_cycles;
    int          err_beat;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    always_comb begin
        bus.hready = 1'b1;
        bus.hresp  = HRESP_OKAY;
        bus.hrdata = '0;
        if (dp_valid && !dp_write) bus.hrdata = mem[dp_addr[11:2]];
        if (dp_valid && dp_idx == err_beat) begin
            bus.hresp  = HRESP_ERROR;
            bus.hready = err_phase;
        end else if (dp_valid && dp_idx == stall_beat && wait_cnt < stall_cycles) begin
            bus.hready = 1'b0;
        end
    end

    always @(posedge hclk) begin
        if (hreset) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_addr   <= '0;
            dp_idx    <= 0;
            beat_next <= 0;
            wait_cnt  <= 0;
            err_phase <= 1'b0;
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        end else if (bus.hready) begin
            if (dp_valid && dp_write && bus.hresp == HRESP_OKAY) mem[dp_addr[11:2]] <= bus.hwdata;
            dp_valid <= bus.htrans[1];
            dp_addr  <= bus.haddr;
            dp_write <= bus.hwrite;
            if (bus.htrans == HTRANS_NONSEQ) begin
                dp_idx    <= 0;
                beat_next <= 1;
            end else if (bus.htrans == HTRANS_SEQ) begin
                dp_idx    <= beat_next;
                beat_next <= beat_next + 1;
            end
            wait_cnt  <= 0;
            err_phase <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt + 1;
            if (dp_valid && dp_idx == err_beat) err_phase <= 1'b1;
        end
    end

    // ---------------- command runner with scoreboard ----------------
    task automatic run_command(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [2:0] burst, output int n_rd, output int n_wr,
                               output int n_addr, output int n_stall, output logic got_done,
                               output logic got_err, output int done_lat);
        int          cyc;
        int          last_dp_cyc;
        logic        prev_err1;
        addr_exp_t   e;
        logic [31:0] tmp;
        n_rd = 0; n_wr = 0; n_addr = 0; n_stall = 0;
        got_done = 1'b0; got_err = 1'b0; done_lat = -1;
        last_dp_cyc = -100; prev_err1 = 1'b0;

        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 20) begin
            @(negedge hclk);
            cyc++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_burst = burst;
        @(negedge hclk);
        cmd_valid = 1'b0;

        for (cyc = 0; cyc < 200 && !got_done; cyc++) begin
            wr_data = (wr_src_q.size() != 0) ? wr_src_q[0] : 32'h0;
            if (wr_ready) begin
                n_wr++;
                if (wr_src_q.size() != 0) tmp = wr_src_q.pop_front();
            end
            if (prev_err1) begin
                n_checks++;
                if (bus.htrans !== HTRANS_IDLE || bus.hsel !== 1'b0) begin
                    n_fail++;
                    $display("FAIL err_abort: htrans=%b hsel=%b want 00/0", bus.htrans, bus.hsel);
                end
            end
            prev_err1 = (bus.hresp == HRESP_ERROR) && !bus.hready;
            if (bus.htrans != HTRANS_IDLE) begin
                n_checks++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_addr: haddr=%h htrans=%b", bus.haddr, bus.htrans);
                end else begin
                    e = exp_addr_q[0];
                    if ({bus.haddr, bus.htrans, bus.hburst, bus.hsize, bus.hsel, bus.hwrite} !==
                        {e.addr, e.trans, e.burst, e.size, 1'b1, wr}) begin
                        n_fail++;
                        $display("FAIL addr_phase: got a=%h t=%b b=%b s=%b sel=%b w=%b want a=%h t=%b b=%b s=%b sel=1 w=%b",
                                 bus.haddr, bus.htrans, bus.hburst, bus.hsize, bus.hsel,
                                 bus.hwrite, e.addr, e.trans, e.burst, e.size, wr);
                    end
                    if (bus.hready) begin
                        e = exp_addr_q.pop_front();
                        n_addr++;
                    end else begin
                        n_stall++;
                    end
                end
            end
            if (dp_valid && bus.hready) last_dp_cyc = cyc;
            if (dp_valid && dp_write && bus.hready && bus.hresp == HRESP_OKAY) begin
                n_checks++;
                if (exp_wdata_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL hwdata_extra: got %h", bus.hwdata);
                end else begin
                    tmp = exp_wdata_q.pop_front();
                    if (bus.hwdata !== tmp) begin
                        n_fail++;
                        $display("FAIL hwdata: got %h want %h", bus.hwdata, tmp);
                    end
                end
            end
            if (rd_valid) begin
                n_rd++;
                n_checks++;
                if (exp_rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_extra: got %h", rd_data);
                end else begin
                    tmp = exp_rd_q.pop_front();
                    if (rd_data !== tmp) begin
                        n_fail++;
                        $display("FAIL rd_data: got %h want %h", rd_data, tmp);
                    end
                end
            end
            if (done) begin
                got_done = 1'b1;
                got_err  = err;
                done_lat = cyc - last_dp_cyc;
            end else begin
                @(negedge hclk);
            end
        end
        n_checks++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL done_timeout: no done within 200 cycles");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cyc;
        hreset = 1'b1;
        repeat (2) @(negedge hclk);
        n_checks++;
        if ({bus.htrans, bus.hsel, cmd_ready, done, err, rd_valid, wr_ready} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: htrans=%b hsel=%b cmd_ready=%b done=%b err=%b rd_valid=%b wr_ready=%b want all 0",
                     bus.htrans, bus.hsel, cmd_ready, done, err, rd_valid, wr_ready);
        end
        hreset = 1'b0;
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 4) begin
            @(negedge hclk);
            cyc++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_single();
        int n_rd, n_wr, n_addr, n_stall, lat;
        logic d, e;
        exp_addr_q.push_back('{32'h40, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD});
        wr_src_q.push_back(32'hDEAD_BEEF);
        exp_wdata_q.push_back(32'hDEAD_BEEF);
        run_command(1'b1, 32'h40, 3'd2, HBURST_SINGLE, n_rd, n_wr, n_addr, n_stall, d, e, lat);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b0 || n_wr != 1 || exp_wdata_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_write: done=%b err=%b wr_ready=%0d pend=%0d want 1/0/1/0",
                     d, e, n_wr, exp_wdata_q.size());
        end
        exp_addr_q.push_back('{32'h40, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD});
        exp_rd_q.push_back(32'hDEAD_BEEF);
        run_command(1'b0, 32'h40, 3'd2, HBURST_SINGLE, n_rd, n_wr, n_addr, n_stall, d, e, lat);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b0 || n_rd != 1 || lat != 1) begin
            n_fail++;
            $display("FAIL single_read: done=%b err=%b rd_valid=%0d lat=%0d want 1/0/1/1",
                     d, e, n_rd, lat);
        end
    endtask

    task automatic test_incr4_write();
        int n_rd, n_wr, n_addr, n_stall, lat;
        logic d, e;
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back('{32'h100 + 32'(4 * i), (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                                   HBURST_INCR4, HSIZE_WORD});
            wr_src_q.push_back(32'h11 * 32'(i + 1));
            exp_wdata_q.push_back(32'h11 * 32'(i + 1));
        end
        run_command(1'b1, 32'h100, 3'd2, HBURST_INCR4, n_rd, n_wr, n_addr, n_stall, d, e, lat);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b0 || n_wr != 4 || n_addr != 4 || lat != 1 ||
            exp_wdata_q.size() != 0) begin
            n_fail++;
            $display("FAIL incr4_write: done=%b err=%b wr_ready=%0d addr=%0d lat=%0d want 1/0/4/4/1",
                     d, e, n_wr, n_addr, lat);
        end
    endtask

    task automatic test_incr8_stall();
        int n_rd, n_wr, n_addr, n_stall, lat;
        logic d, e;
        stall_beat = 2;
        stall_cycles = 2;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back('{32'h200 + 32'(i), (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                                   HBURST_INCR8, HSIZE_BYTE});
            exp_rd_q.push_back(pat((32'h200 + i) >> 2));
        end
        run_command(1'b0, 32'h200, 3'd0, HBURST_INCR8, n_rd, n_wr, n_addr, n_stall, d, e, lat);
        stall_beat = -1;
        n_checks++;
        if (d !== 1'b1 || e !== 1'b0 || n_rd != 8 || n_addr != 8 || n_stall != 2) begin
            n_fail++;
            $display("FAIL incr8_stall: done=%b err=%b rd=%0d addr=%0d stall=%0d want 1/0/8/8/2",
                     d, e, n_rd, n_addr, n_stall);
        end
    endtask

    task automatic test_error();
        int n_rd, n_wr, n_addr, n_stall, lat;
        logic d, e;
        err_beat = 1;
        // Beat 2's address is presented during the error's first cycle but never completes.
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back('{32'h300 + 32'(4 * i), (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                                   HBURST_INCR4, HSIZE_WORD});
        end
        exp_rd_q.push_back(pat(32'h300 >> 2));
        run_command(1'b0, 32'h300, 3'd2, HBURST_INCR4, n_rd, n_wr, n_addr, n_stall, d, e, lat);
        err_beat = -1;
        n_checks++;
        if (d !== 1'b1 || e !== 1'b1 || n_rd != 1 || n_addr != 2 || n_stall != 1 ||
            exp_addr_q.size() != 1) begin
            n_fail++;
            $display("FAIL error_burst: done=%b err=%b rd=%0d addr=%0d stall=%0d left=%0d want 1/1/1/2/1/1",
                     d, e, n_rd, n_addr, n_stall, exp_addr_q.size());
        end
        exp_addr_q.delete();
    endtask

    task automatic test_reset_mid();
        int   n_rd, n_wr, n_addr, n_stall, lat, cyc;
        logic d, e, saw_done;
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 20) begin
            @(negedge hclk);
            cyc++;
        end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h400; cmd_size = 3'd2;
        cmd_burst = HBURST_INCR16;
        @(negedge hclk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr_data = 32'h5000_0000 + 32'(k);
            @(negedge hclk);
        end
        n_checks++;
        if (bus.htrans !== HTRANS_SEQ || bus.haddr !== 32'h414) begin
            n_fail++;
            $display("FAIL mid_burst: htrans=%b haddr=%h want 11/00000414", bus.htrans, bus.haddr);
        end
        hreset = 1'b1;
        @(negedge hclk);
        n_checks++;
        if (bus.htrans !== HTRANS_IDLE || bus.hsel !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: htrans=%b hsel=%b done=%b cmd_ready=%b want 00/0/0/0",
                     bus.htrans, bus.hsel, done, cmd_ready);
        end
        hreset = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge hclk);
            if (done === 1'b1 || bus.htrans !== HTRANS_IDLE) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet: activity or done after reset got %b want 0", saw_done);
        end
        exp_addr_q.push_back('{32'h40, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_WORD});
        exp_rd_q.push_back(pat(32'h40 >> 2));
        run_command(1'b0, 32'h40, 3'd2, HBURST_SINGLE, n_rd, n_wr, n_addr, n_stall, d, e, lat);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b0 || n_rd != 1) begin
            n_fail++;
            $display("FAIL post_reset_cmd: done=%b err=%b rd=%0d want 1/0/1", d, e, n_rd);
        end
    endtask

    task automatic test_wrap();
        int          n_rd, n_wr, n_addr, n_stall, lat;
        logic        d, e;
        logic [31:0] a;
        logic [2:0]  hb;
`ifdef AHB_SRAM_MST_WRAP_EN
        logic [31:0] exp_a [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
        hb = HBURST_WRAP4;
`else
        logic [31:0] exp_a [4] = '{32'h38, 32'h3C, 32'h40, 32'h44};
        hb = HBURST_INCR4;
`endif
        for (int i = 0; i < 4; i++) begin
            a = exp_a[i];
            exp_addr_q.push_back('{a, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, hb, HSIZE_WORD});
            exp_rd_q.push_back(pat(int'(a >> 2)));
        end
        run_command(1'b0, 32'h38, 3'd2, HBURST_WRAP4, n_rd, n_wr, n_addr, n_stall, d, e, lat);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b0 || n_rd != 4 || n_addr != 4) begin
            n_fail++;
            $display("FAIL wrap4: done=%b err=%b rd=%0d addr=%0d want 1/0/4/4", d, e, n_rd, n_addr);
        end
    endtask

    initial begin
        hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
        cmd_burst = '0; wr_data = '0;
        stall_beat = -1; stall_cycles = 0; err_beat = -1;
        test_reset();
        test_single();
        test_incr4_write();
        test_incr8_stall();
        test_error();
        test_reset_mid();
        test_wrap();
        repeat (3) @(negedge hclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
